// File: rtl/delay_pipe.sv
// Variable-latency delay line: DEPTH valid-qualified register stages with a
// runtime-selected output tap and a count of valid samples ahead of the tap.
module delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  localparam int DW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [DW-1:0]    delay,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [DW-1:0]    inflight
);

  localparam logic [DW-1:0] DEPTH_DW = DW'(DEPTH);

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
    if (d == '0) return DW'(1);
    if (d > DEPTH_DW) return DEPTH_DW;
    return d;
  endfunction

  logic [WIDTH-1:0] pipe_data [DEPTH];
  logic [DEPTH-1:0] pipe_vld;
  logic [DW-1:0]    eff;
  logic [DW-1:0]    tap;

  assign eff = clamp_delay(delay);
  assign tap = eff - DW'(1);

  // Stage registers: stage 0 captures the input, stage i follows stage i-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_data[i] <= '0;
    end else if (flush) begin
      pipe_vld <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_data[i] <= '0;
    end else if (en) begin
      pipe_vld[0]  <= in_valid;
      pipe_data[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // Output tap and occupancy read only registered state, so in_* never reaches out_*.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    inflight  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i) == tap) begin
        out_valid = pipe_vld[i];
        out_data  = pipe_data[i];
      end
      if ((DW'(i) < eff) && pipe_vld[i]) inflight = inflight + DW'(1);
    end
  end

endmodule
